// File: rtl/mio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mio_bus_arbiter
// Purpose  : Two-master round-robin arbiter and access sequencer for the
//            shared memory/IO bus. Master 0 is the CPU, master 1 a secondary
//            requester (DMA/debug). The winner's command is latched, the
//            MIO_ready wait-state handshake is run, and read data is returned
//            alongside a one-cycle ready pulse.
// Options  : `define MIO_ARB_TIMEOUT_EN adds a watchdog that aborts an access
//            after TIMEOUT unacknowledged ACCESS cycles (m_err = 1).
// Ports    : Clk_CPU, rst (sync, active-low)
//            m0_*/m1_*   : master request/command in, rdata/ready out
//            m_err       : timeout flag, valid with the ready pulse
//            bus_*       : latched command towards memory/IO, bus_rdata in
//            MIO_ready   : bus acknowledge (only honoured during ACCESS)
//            CPU_MIO     : master 0 owns an active access
//            grant       : one-hot owner, 0 when idle
// Revision : 1.0 - initial release
// ============================================================================
module mio_bus_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          Clk_CPU,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic          m0_we,
    input  logic          m1_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m0_ready,
    output logic          m1_ready,
    output logic          m_err,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          MIO_ready,
    output logic          CPU_MIO,
    output logic [1:0]    grant
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_q, last_d;      // 0: m0 granted last, 1: m1 granted last
    logic          bus_we_q, bus_we_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

`ifdef MIO_ARB_TIMEOUT_EN
    localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);
    logic          err_q, err_d;
    logic [7:0]    cnt_q, cnt_d;
`else
    logic          w_unused_timeout;
    assign w_unused_timeout = ^8'(TIMEOUT);
`endif

    logic          w_pick_m1;
    logic [DW-1:0] w_resp_data;

    // m1 wins when it is the only requester, or on a tie when m0 went last.
    assign w_pick_m1   = m1_req & (~m0_req | ~last_q);
    // Writes complete with zero read data.
    assign w_resp_data = bus_we_q ? '0 : bus_rdata;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
`ifdef MIO_ARB_TIMEOUT_EN
        err_d       = err_q;
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (m0_req | m1_req) begin
                    state_d     = ST_ACCESS;
                    grant_d     = w_pick_m1 ? 2'b10 : 2'b01;
                    last_d      = w_pick_m1;
                    bus_we_d    = w_pick_m1 ? m1_we    : m0_we;
                    bus_addr_d  = w_pick_m1 ? m1_addr  : m0_addr;
                    bus_wdata_d = w_pick_m1 ? m1_wdata : m0_wdata;
`ifdef MIO_ARB_TIMEOUT_EN
                    cnt_d       = 8'd0;
                    err_d       = 1'b0;
`endif
                end
            end
            ST_ACCESS: begin
                // An acknowledge in the limit cycle still completes normally.
                if (MIO_ready) begin
                    state_d = ST_RESP;
                    if (grant_q[0]) begin
                        rdata0_d = w_resp_data;
                    end else begin
                        rdata1_d = w_resp_data;
                    end
                end
`ifdef MIO_ARB_TIMEOUT_EN
                else if (cnt_q == C_TO_LAST) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    if (grant_q[0]) begin
                        rdata0_d = '0;
                    end else begin
                        rdata1_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge Clk_CPU) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= 2'b00;
            last_q      <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
`ifdef MIO_ARB_TIMEOUT_EN
            err_q       <= 1'b0;
            cnt_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
`ifdef MIO_ARB_TIMEOUT_EN
            err_q       <= err_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus_req   = (state_q == ST_ACCESS);
    assign CPU_MIO   = grant_q[0] & bus_req;
    assign m0_ready  = (state_q == ST_RESP) & grant_q[0];
    assign m1_ready  = (state_q == ST_RESP) & grant_q[1];
    assign grant     = grant_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
`ifdef MIO_ARB_TIMEOUT_EN
    assign m_err     = (state_q == ST_RESP) & err_q;
`else
    assign m_err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mio_bus_arbiter
// Purpose  : Self-checking bench for mio_bus_arbiter. A transaction-level
//            reference model predicts every output each cycle; directed
//            steps cover reset, wait states, contention, mid-access
//            requests, timeout/no-timeout and reset mid-access, followed by
//            randomized traffic. Honours `MIO_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mio_bus_arbiter;
    localparam int TIMEOUT = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
`ifdef MIO_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          Clk_CPU = 1'b0;
    logic          rst;
    logic          m0_req, m1_req, m0_we, m1_we;
    logic [AW-1:0] m0_addr, m1_addr, bus_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, bus_wdata, bus_rdata;
    logic          m0_ready, m1_ready, m_err, bus_req, bus_we, MIO_ready, CPU_MIO;
    logic [1:0]    grant;

    mio_bus_arbiter #(.TIMEOUT(TIMEOUT), .AW(AW), .DW(DW)) dut (
        .Clk_CPU(Clk_CPU), .rst(rst),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_ready(m0_ready), .m1_ready(m1_ready),
        .m_err(m_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .MIO_ready(MIO_ready),
        .CPU_MIO(CPU_MIO), .grant(grant)
    );

    always #5 Clk_CPU = ~Clk_CPU;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: phase 0 = arbitrating, 1 = bus access, 2 = response.
    int            ph = 0, owner = -1, last = 1, waited = 0;
    bit            acc_new = 1'b0;
    logic          x_we = 1'b0, x_err = 1'b0;
    logic [AW-1:0] x_addr = '0;
    logic [DW-1:0] x_wdata = '0;
    logic [DW-1:0] x_rd [2];

    // Traffic generator controls.
    bit            cont [2];
    bit            en [2];
    int            gap [2];
    int            waits_left = 0, fixed_wait = 0;
    bit            fixed_wait_en = 1'b0, fixed_rdata_en = 1'b0, never_ready = 1'b0, noise = 1'b1;
    logic [DW-1:0] fixed_rdata = '0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_master(input int n, input bit rq, input bit we,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (n == 0) begin m0_req = rq; m0_we = we; m0_addr = a; m0_wdata = d; end
        else        begin m1_req = rq; m1_we = we; m1_addr = a; m1_wdata = d; end
    endtask

    task automatic model_step();
        bit r0, r1;
        int w;
        r0 = m0_req;
        r1 = m1_req;
        if (!rst) begin
            ph = 0; owner = -1; last = 1; waited = 0;
            x_we = 1'b0; x_addr = '0; x_wdata = '0; x_err = 1'b0;
            x_rd[0] = '0; x_rd[1] = '0;
        end else if (ph == 0) begin
            if (r0 || r1) begin
                if (r0 && r1) w = 1 - last;
                else          w = r0 ? 0 : 1;
                owner   = w;
                last    = w;
                x_we    = (w == 1) ? m1_we    : m0_we;
                x_addr  = (w == 1) ? m1_addr  : m0_addr;
                x_wdata = (w == 1) ? m1_wdata : m0_wdata;
                x_err   = 1'b0;
                waited  = 0;
                ph      = 1;
                acc_new = 1'b1;
            end
        end else if (ph == 1) begin
            if (MIO_ready) begin
                x_rd[owner] = x_we ? '0 : bus_rdata;
                ph = 2;
            end else begin
                waited++;
                if (TO_EN && waited >= TIMEOUT) begin
                    x_rd[owner] = '0;
                    x_err = 1'b1;
                    ph = 2;
                end
            end
        end else begin
            ph = 0;
            owner = -1;
        end
    endtask

    task automatic check_outputs();
        logic [1:0] eg;
        eg = (ph == 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
        chk("grant",    96'(grant),    96'(eg));
        chk("bus_req",  96'(bus_req),  96'(ph == 1));
        chk("CPU_MIO",  96'(CPU_MIO),  96'(ph == 1 && owner == 0));
        chk("m0_ready", 96'(m0_ready), 96'(ph == 2 && owner == 0));
        chk("m1_ready", 96'(m1_ready), 96'(ph == 2 && owner == 1));
        chk("m_err",    96'(m_err),    96'(ph == 2 && x_err));
        chk("m0_rdata", 96'(m0_rdata), 96'(x_rd[0]));
        chk("m1_rdata", 96'(m1_rdata), 96'(x_rd[1]));
        chk("bus_cmd",  96'({bus_we, bus_addr, bus_wdata}), 96'({x_we, x_addr, x_wdata}));
    endtask

    task automatic drive();
        bit rq;
        for (int n = 0; n < 2; n++) begin
            rq = (n == 1) ? m1_req : m0_req;
            if (rq) begin
                if (ph == 2 && owner == n && !cont[n]) begin
                    if (n == 0) m0_req = 1'b0; else m1_req = 1'b0;
                    gap[n] = $urandom_range(0, 3);
                end
            end else if (en[n]) begin
                if (gap[n] == 0) set_master(n, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
                else             gap[n]--;
            end
        end
        if (ph == 1) begin
            if (acc_new) begin
                acc_new    = 1'b0;
                waits_left = fixed_wait_en ? fixed_wait : $urandom_range(0, 5);
                bus_rdata  = fixed_rdata_en ? fixed_rdata : $urandom;
            end
            if (never_ready)          MIO_ready = 1'b0;
            else if (waits_left == 0) MIO_ready = 1'b1;
            else begin MIO_ready = 1'b0; waits_left--; end
        end else begin
            MIO_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_rdata = $urandom;
        end
    endtask

    task automatic tick();
        @(posedge Clk_CPU);
        model_step();
        @(negedge Clk_CPU);
        check_outputs();
        drive();
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 80 && !(grant == 2'b00 && !m0_req && !m1_req); i++) tick();
        chk(tag, 96'(grant == 2'b00 && !m0_req && !m1_req), 96'(1));
    endtask

    initial begin
        logic [1:0]    gseq [4];
        logic [1:0]    prev_g;
        logic [DW-1:0] rd_seen;
        logic          err_seen;
        int            gn, cnt_req, cnt_mio, cnt_rdy;
        bit            seen;

        rst = 1'b0; MIO_ready = 1'b0; bus_rdata = '0;
        set_master(0, 1'b0, 1'b0, '0, '0);
        set_master(1, 1'b0, 1'b0, '0, '0);
        x_rd[0] = '0; x_rd[1] = '0;
        for (int n = 0; n < 2; n++) begin cont[n] = 1'b0; en[n] = 1'b0; gap[n] = 0; end
        for (int k = 0; k < 4; k++) gseq[k] = 2'b00;

        // Reset held with both masters requesting, then continuous contention.
        set_master(0, 1'b1, 1'b1, 32'h0000_0100, 32'h1111_0000);
        set_master(1, 1'b1, 1'b1, 32'h0000_0200, 32'h2222_0000);
        cont[0] = 1'b1; cont[1] = 1'b1;
        repeat (3) tick();
        chk("reset_grant",   96'(grant),   96'(2'b00));
        chk("reset_bus_req", 96'(bus_req), 96'(0));
        rst = 1'b1;
        gn = 0; prev_g = 2'b00;
        for (int i = 0; i < 60 && gn < 4; i++) begin
            tick();
            if (grant != 2'b00 && prev_g == 2'b00) begin gseq[gn] = grant; gn++; end
            prev_g = grant;
        end
        chk("contention_count", 96'(gn), 96'(4));
        chk("contention_g0", 96'(gseq[0]), 96'(2'b01));
        chk("contention_g1", 96'(gseq[1]), 96'(2'b10));
        chk("contention_g2", 96'(gseq[2]), 96'(2'b01));
        chk("contention_g3", 96'(gseq[3]), 96'(2'b10));
        cont[0] = 1'b0; cont[1] = 1'b0;
        wait_idle("contention_drain");

        // Single m0 read with two wait states.
        fixed_wait_en = 1'b1; fixed_wait = 2;
        fixed_rdata_en = 1'b1; fixed_rdata = 32'hCAFE_F00D;
        set_master(0, 1'b1, 1'b0, 32'h0000_0010, '0);
        cnt_req = 0; cnt_mio = 0; cnt_rdy = 0; rd_seen = '0; err_seen = 1'b1;
        repeat (7) begin
            tick();
            if (bus_req) cnt_req++;
            if (CPU_MIO) cnt_mio++;
            if (m0_ready) begin cnt_rdy++; rd_seen = m0_rdata; err_seen = m_err; end
        end
        chk("read_bus_req_cycles", 96'(cnt_req), 96'(3));
        chk("read_cpu_mio_cycles", 96'(cnt_mio), 96'(3));
        chk("read_ready_pulses",   96'(cnt_rdy), 96'(1));
        chk("read_rdata",          96'(rd_seen), 96'(32'hCAFE_F00D));
        chk("read_err",            96'(err_seen), 96'(0));

        // m1 write; m0 requests during m1's access.
        fixed_wait = 3;
        set_master(1, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0055);
        for (int i = 0; i < 10 && !(grant == 2'b10 && bus_req); i++) tick();
        chk("mid_m1_granted", 96'(grant == 2'b10 && bus_req), 96'(1));
        set_master(0, 1'b1, 1'b0, 32'h0000_0044, '0);
        for (int i = 0; i < 20 && !m1_ready; i++) tick();
        chk("mid_m1_ready", 96'(m1_ready), 96'(1));
        chk("mid_bus_cmd", 96'({bus_we, bus_addr, bus_wdata}), 96'({1'b1, 32'h20, 32'h55}));
        chk("mid_m1_rdata", 96'(m1_rdata), 96'(0));
        tick();
        chk("mid_idle_gap", 96'(grant), 96'(2'b00));
        tick();
        chk("mid_m0_next", 96'(grant), 96'(2'b01));
        wait_idle("mid_drain");

`ifdef MIO_ARB_TIMEOUT_EN
        // Known read data first so the timeout's zero return is visible.
        fixed_wait = 0; fixed_rdata = 32'h1234_5678;
        set_master(1, 1'b1, 1'b0, 32'h0000_0030, '0);
        for (int i = 0; i < 10 && !m1_ready; i++) tick();
        chk("to_pre_rdata", 96'(m1_rdata), 96'(32'h1234_5678));
        wait_idle("to_pre_drain");
        never_ready = 1'b1;
        set_master(1, 1'b1, 1'b0, 32'h0000_0034, '0);
        cnt_req = 0;
        for (int i = 0; i < 20 && !m1_ready; i++) begin tick(); if (bus_req) cnt_req++; end
        chk("to_access_cycles", 96'(cnt_req), 96'(TIMEOUT));
        chk("to_err",   96'(m_err),    96'(1));
        chk("to_rdata", 96'(m1_rdata), 96'(0));
        wait_idle("to_drain");
        never_ready = 1'b0; fixed_wait = TIMEOUT - 1; fixed_rdata = 32'hA5A5_0001;
        set_master(1, 1'b1, 1'b0, 32'h0000_0038, '0);
        cnt_req = 0;
        for (int i = 0; i < 20 && !m1_ready; i++) begin tick(); if (bus_req) cnt_req++; end
        chk("to_edge_cycles", 96'(cnt_req), 96'(TIMEOUT));
        chk("to_edge_err",   96'(m_err),    96'(0));
        chk("to_edge_rdata", 96'(m1_rdata), 96'(32'hA5A5_0001));
        wait_idle("to_edge_drain");
`else
        // Without the watchdog an unacknowledged access never completes.
        never_ready = 1'b1;
        set_master(1, 1'b1, 1'b0, 32'h0000_0034, '0);
        cnt_req = 0; cnt_rdy = 0;
        repeat (100) begin
            tick();
            if (bus_req) cnt_req++;
            if (m0_ready || m1_ready) cnt_rdy++;
        end
        chk("hang_bus_req_cycles", 96'(cnt_req), 96'(100));
        chk("hang_ready_pulses",   96'(cnt_rdy), 96'(0));
        rst = 1'b0;
        tick();
        rst = 1'b1; never_ready = 1'b0;
        wait_idle("hang_drain");
`endif

        // Reset while m0 is mid-access with m1 waiting.
        fixed_wait = 5;
        set_master(0, 1'b1, 1'b0, 32'h0000_0080, '0);
        for (int i = 0; i < 10 && !(grant == 2'b01 && bus_req); i++) tick();
        chk("rst_m0_granted", 96'(grant == 2'b01 && bus_req), 96'(1));
        tick();
        set_master(1, 1'b1, 1'b0, 32'h0000_0090, '0);
        rst = 1'b0;
        tick();
        chk("rst_bus_req",  96'(bus_req),  96'(0));
        chk("rst_m0_ready", 96'(m0_ready), 96'(0));
        rst = 1'b1;
        tick();
        chk("rst_tie_to_m0", 96'(grant), 96'(2'b01));
        wait_idle("rst_drain");

        // Randomized traffic with occasional resets.
        fixed_wait_en = 1'b0; fixed_rdata_en = 1'b0;
        en[0] = 1'b1; en[1] = 1'b1;
        seen = 1'b0;
        repeat (400) begin
            rst = ($urandom_range(0, 39) != 0);
            tick();
            if (m0_ready || m1_ready) seen = 1'b1;
        end
        rst = 1'b1;
        chk("rand_any_completion", 96'(seen), 96'(1));
        en[0] = 1'b0; en[1] = 1'b0;
        wait_idle("rand_drain");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mio_bus_arbiter.md
# mio_bus_arbiter

Two-master arbiter and access sequencer for the shared memory/IO bus of the multi-cycle SoC. Master 0 is the CPU and master 1 is a secondary requester (DMA or debug port). The block grants the bus round-robin and latches the winner's command. It runs the MIO_ready wait-state handshake and returns read data with a one-cycle ready pulse. An optional watchdog aborts accesses the bus never acknowledges.

## Interface
- TIMEOUT, 16: ACCESS cycles allowed without MIO_ready before abort; legal range 2..255.
- AW, 32: address width.
- DW, 32: data width.

- Clk_CPU  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- m0_req, m1_req  in  1  access request; held until the matching mN_ready.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  AW  address.
- m0_wdata, m1_wdata  in  DW  write data.
- m0_rdata, m1_rdata  out  DW  read data; valid during the mN_ready cycle.
- m0_ready, m1_ready  out  1  one-cycle completion pulse.
- m_err  out  1  high with mN_ready when the access timed out.
- bus_req  out  1  bus access strobe.
- bus_we  out  1  latched write enable.
- bus_addr  out  AW  latched address.
- bus_wdata  out  DW  latched write data.
- bus_rdata  in  DW  read data from memory/IO.
- MIO_ready  in  1  bus acknowledge; accepted only while bus_req = 1.
- CPU_MIO  out  1  high while master 0 owns an active access.
- grant  out  2  one-hot owner: bit0 = m0, bit1 = m1; 0 when idle.

## Operation
- States:
  - IDLE: arbitration.
  - ACCESS: bus_req = 1, waiting for MIO_ready.
  - RESP: mN_ready pulse.
- IDLE:
  - Samples m0_req and m1_req.
  - Only one request high: that master wins.
  - Both high: the master not equal to last_grant wins.
  - On a win, latch we/addr/wdata into bus_we/bus_addr/bus_wdata.
  - Set grant, update last_grant, go to ACCESS.
- ACCESS:
  - bus_req = 1.
  - MIO_ready = 1: capture bus_rdata (reads only; writes return 0) into the owner's mN_rdata, go to RESP.
- RESP:
  - Owner's mN_ready = 1 for exactly one cycle; m_err per timeout rule.
  - No arbitration; go to IDLE.
  - The master must drop mN_req during its RESP cycle, or it is treated as a new request in IDLE.
- Masters do not change command inputs while mN_req is high. Changes after the grant edge are ignored.
- A request raised and dropped between IDLE samples is never seen.
- The non-owner's mN_ready and mN_rdata stay 0 and hold their previous value, respectively.
- CPU_MIO = grant[0] & (state == ACCESS).
- grant stays set through ACCESS and RESP and clears on return to IDLE.

## Timing
- Reset (rst = 0 at an edge):
  - state = IDLE, last_grant = 1 (master 0 wins the first tie), timeout counter = 0.
  - All outputs 0: bus_req, bus_we, bus_addr, bus_wdata, m0/m1_rdata, m0/m1_ready, m_err, CPU_MIO, grant.
- Reset during ACCESS or RESP:
  - Aborts at that edge; bus_req falls and no ready pulse is produced.
- Zero-wait access:
  - Request sampled at edge 0.
  - bus_req high in cycle 1; MIO_ready = 1 in cycle 1.
  - mN_ready in cycle 2; back in IDLE in cycle 3.
  - Minimum 3 cycles per transaction.
- N wait states add N cycles in ACCESS.
- Back-to-back with both masters requesting continuously: grants alternate m0, m1, m0, ... with one IDLE cycle between them.
- MIO_ready while not in ACCESS is ignored.

## Configuration
- MIO_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on ACCESS entry and increments each ACCESS cycle with MIO_ready = 0.
  - If the counter reaches TIMEOUT with MIO_ready still 0, go to RESP with m_err = 1 and mN_rdata = 0.
  - MIO_ready = 1 in the same cycle the limit is reached wins: normal completion with m_err = 0.
- MIO_ARB_TIMEOUT_EN not defined:
  - No counter; ACCESS waits indefinitely.
  - m_err is tied 0.

## Test plan
- Reset: hold rst = 0 for 3 edges with both requests high -> all outputs 0, grant = 0, no bus_req.
- Single read: m0 reads 0x0000_0010, MIO_ready after 2 wait states, bus_rdata = 0xCAFE_F00D -> bus_req high for 3 cycles, CPU_MIO = 1 in those cycles, m0_ready pulses once with m0_rdata = 0xCAFE_F00D, m_err = 0.
- Contention: m0 and m1 request simultaneously and continuously for 4 transactions -> grant order 01, 10, 01, 10; CPU_MIO high only during m0 ACCESS; write address/data match the granted master.
- Mid-access request: m1 writes 0x55 to 0x20; m0 raises req during m1's ACCESS -> m1 completes untouched, m0 is granted on the next IDLE.
- Timeout (macro defined, TIMEOUT = 4): m1 reads, MIO_ready never asserts -> after 4 ACCESS cycles m1_ready = 1, m_err = 1, m1_rdata = 0. Repeat with MIO_ready = 1 on the 4th cycle -> m_err = 0. Macro undefined -> bus_req stays high for 100 cycles, no ready pulse.
- Reset mid-access: rst = 0 during m0's ACCESS -> bus_req is 0 after that edge and no m0_ready pulse; the next tie after reset is granted to m0.
